// File: rtl/cost_table_loader.sv
// Loads a 64-entry x 7-bit cost table (W*8+J) from a valid/ready stream and serves combinational reads.
// Optional running sum of loaded costs enabled by defining COST_SUM_EN.
module cost_table_loader (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [6:0]  in_data,
    output logic        in_ready,
    input  logic        clear,
    input  logic [2:0]  W,
    input  logic [2:0]  J,
    output logic [6:0]  Cost,
    output logic        table_ready,
    output logic        jam_rst,
    output logic [12:0] sum_total
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_READY,
        ST_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  load_cnt_q, load_cnt_d;
    logic        table_ready_q, table_ready_d;
    logic        ready_seen_q, ready_seen_d;
    logic        xfer;
    logic [6:0]  mem [64];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_LOAD;
            load_cnt_q    <= '0;
            table_ready_q <= 1'b0;
            ready_seen_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            table_ready_q <= table_ready_d;
            ready_seen_q  <= ready_seen_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_cnt_d    = load_cnt_q;
        table_ready_d = table_ready_q;
        ready_seen_d  = (state_q == ST_READY);
        // clear wins over a concurrent transfer by masking in_ready
        in_ready      = (state_q == ST_LOAD) && !clear;
        xfer          = in_valid && in_ready;

        if (clear) begin
            state_d       = ST_FLUSH;
            load_cnt_d    = '0;
            table_ready_d = 1'b0;
            ready_seen_d  = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (xfer) begin
                        load_cnt_d = load_cnt_q + 6'd1;
                        if (load_cnt_q == 6'd63) begin
                            state_d       = ST_READY;
                            table_ready_d = 1'b1;
                        end
                    end
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                ST_FLUSH: begin
                    load_cnt_d    = '0;
                    table_ready_d = 1'b0;
                    state_d       = ST_LOAD;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    // Engine stays in reset until it has seen one full cycle with the complete table
    assign jam_rst     = (state_q != ST_READY) || !ready_seen_q;
    assign table_ready = table_ready_q;

    always_ff @(posedge CLK) begin
        if (xfer) begin
            mem[load_cnt_q] <= in_data;
        end
    end

    assign Cost = mem[{W, J}];

`ifdef COST_SUM_EN
    logic [12:0] sum_q, sum_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    always_comb begin
        sum_d = sum_q;
        if (state_q == ST_FLUSH) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + {6'd0, in_data};
        end
    end

    assign sum_total = sum_q;
`else
    assign sum_total = '0;
`endif

endmodule

// File: tb/tb_cost_table_loader.sv
// Directed, self-checking bench for cost_table_loader: table-driven read vectors plus
// hand-written load / clear / reset sequences. Sum expectations follow COST_SUM_EN.
module tb_cost_table_loader;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic [6:0]  in_data;
    logic        in_ready;
    logic        clear;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic        table_ready;
    logic        jam_rst;
    logic [12:0] sum_total;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef COST_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        int         cost;
    } vec_t;

    vec_t vecs [8];

    cost_table_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .clear       (clear),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .jam_rst     (jam_rst),
        .sum_total   (sum_total)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic xfer_one(input int d);
        in_valid = 1'b1;
        in_data  = 7'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_at(input int w, input int j);
        W = 3'(w);
        J = 3'(j);
        #1;
    endtask

    task automatic check_vecs(input string nm, input int offset);
        for (int k = 0; k < 8; k++) begin
            read_at(int'(vecs[k].w), int'(vecs[k].j));
            chk(nm, int'(Cost), vecs[k].cost + offset);
        end
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("clear_in_ready", int'(in_ready), 0);
        tick();
        clear = 1'b0;
        chk("flush_table_ready", int'(table_ready), 0);
        chk("flush_jam_rst", int'(jam_rst), 1);
        chk("flush_in_ready", int'(in_ready), 0);
        tick();
        chk("after_flush_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; W = '0; J = '0;

        // entry index = W*8+J, loaded value = index mod 100
        vecs[0] = '{w: 3'd0, j: 3'd0, cost: 0};
        vecs[1] = '{w: 3'd0, j: 3'd1, cost: 1};
        vecs[2] = '{w: 3'd1, j: 3'd0, cost: 8};
        vecs[3] = '{w: 3'd3, j: 3'd5, cost: 29};
        vecs[4] = '{w: 3'd4, j: 3'd4, cost: 36};
        vecs[5] = '{w: 3'd6, j: 3'd1, cost: 49};
        vecs[6] = '{w: 3'd7, j: 3'd6, cost: 62};
        vecs[7] = '{w: 3'd7, j: 3'd7, cost: 63};

        #12;
        chk("rst_table_ready", int'(table_ready), 0);
        chk("rst_jam_rst", int'(jam_rst), 1);
        chk("rst_sum", int'(sum_total), 0);
        tick();
        RST = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        // back-to-back full load
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("load_last_table_ready", int'(table_ready), 0);
            xfer_one(i % 100);
        end
        chk("ready_table_ready", int'(table_ready), 1);
        chk("ready_first_jam_rst", int'(jam_rst), 1);
        chk("ready_in_ready", int'(in_ready), 0);
        tick();
        chk("ready_second_jam_rst", int'(jam_rst), 0);
        chk("sum_seq", int'(sum_total), SUM_EN ? 2016 : 0);
        check_vecs("vec_seq", 0);

        // writes ignored while READY
        in_valid = 1'b1;
        in_data  = 7'd127;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        read_at(0, 0);
        chk("ready_readonly_00", int'(Cost), 0);
        check_vecs("vec_readonly", 0);
        chk("ready_readonly_sum", int'(sum_total), SUM_EN ? 2016 : 0);

        // in_valid toggling, value = index + 64
        do_clear();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b0;
            tick();
            xfer_one(i + 64);
        end
        chk("toggle_table_ready", int'(table_ready), 1);
        chk("toggle_in_ready", int'(in_ready), 0);
        check_vecs("vec_toggle", 64);

        // clear coincident with transfer 30, then reload of all 5s
        do_clear();
        for (int i = 0; i < 30; i++) xfer_one(i + 1);
        in_valid = 1'b1;
        in_data  = 7'd99;
        clear    = 1'b1;
        #1;
        chk("clear_xfer_in_ready", int'(in_ready), 0);
        tick();
        clear    = 1'b0;
        in_data  = 7'd5;
        chk("flush30_in_ready", int'(in_ready), 0);
        chk("flush30_jam_rst", int'(jam_rst), 1);
        tick();
        chk("flush30_reload_ready", int'(in_ready), 1);
        for (int i = 0; i < 63; i++) tick();
        chk("reload63_table_ready", int'(table_ready), 0);
        tick();
        in_valid = 1'b0;
        chk("reload64_table_ready", int'(table_ready), 1);
        for (int w = 0; w < 8; w++) begin
            for (int j = 0; j < 8; j++) begin
                read_at(w, j);
                chk("all_fives", int'(Cost), 5);
            end
        end
        chk("sum_fives", int'(sum_total), SUM_EN ? 320 : 0);

        // asynchronous reset in the middle of transfer 40
        do_clear();
        for (int i = 0; i < 40; i++) xfer_one(i + 10);
        in_valid = 1'b1;
        in_data  = 7'd77;
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_table_ready", int'(table_ready), 0);
        chk("async_rst_jam_rst", int'(jam_rst), 1);
        chk("async_rst_sum", int'(sum_total), 0);
        tick();
        in_valid = 1'b0;
        RST = 1'b0;
        for (int i = 0; i < 64; i++) xfer_one(2 * i);
        chk("post_rst_table_ready", int'(table_ready), 1);
        read_at(0, 0);
        chk("post_rst_00", int'(Cost), 0);
        read_at(0, 1);
        chk("post_rst_01", int'(Cost), 2);
        read_at(3, 5);
        chk("post_rst_35", int'(Cost), 58);
        read_at(7, 7);
        chk("post_rst_77", int'(Cost), 126);
        chk("sum_double", int'(sum_total), SUM_EN ? 4032 : 0);

        // all-127 load: maximum sum
        do_clear();
        for (int i = 0; i < 64; i++) xfer_one(127);
        chk("max_table_ready", int'(table_ready), 1);
        read_at(7, 7);
        chk("max_77", int'(Cost), 127);
        chk("sum_max", int'(sum_total), SUM_EN ? 8128 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
